// File: rtl/i2c_slave_regfile.sv
// Bit-serial I2C slave backed by a DEPTH x 8 register file with an auto-incrementing pointer.
// SCL/SDA are oversampled by s_CLK. Register writes are reported to local logic through a strobe.
module i2c_slave_regfile #(
    parameter logic [6:0] ADDRESS    = 7'h55,
    parameter int         DEPTH      = 16,
    parameter int         AW         = 4,
    parameter logic [7:0] RESET_DATA = 8'hC3
) (
    input  logic          s_CLK,
    input  logic          s_RSTn,
    input  logic          s_SCL,
    input  logic          si_SDA,
    output logic          so_SDA_OE,
    output logic          s_ACK,
    output logic          s_BUSY,
    output logic          wr_STB,
    output logic [AW-1:0] wr_ADDR,
    output logic [7:0]    wr_DATA,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_PTR      = 3'd3,
        ST_WDATA    = 3'd4,
        ST_DACK     = 3'd5,
        ST_RDATA    = 3'd6,
        ST_RACK     = 3'd7
    } state_t;

    logic rst_meta_q, rst_sync_q;
    logic scl_s1_q, scl_s2_q, scl_d3_q;
    logic sda_s1_q, sda_s2_q, sda_d3_q;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      tx_q, tx_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            oe_q, oe_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [7:0]      wd_q, wd_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic            scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0]      rx_next, rd_byte;
    logic [AW-1:0]   ptr_inc;

    // Reset asserts asynchronously everywhere but is released on a clock edge.
    always_ff @(posedge s_CLK or negedge s_RSTn) begin
        if (!s_RSTn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Synchronisers reset to the idle-bus level so no false edge is seen on release.
    always_ff @(posedge s_CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d3_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d3_q <= 1'b1;
        end else begin
            scl_s1_q <= s_SCL;
            scl_s2_q <= scl_s1_q;
            scl_d3_q <= scl_s2_q;
            sda_s1_q <= si_SDA;
            sda_s2_q <= sda_s1_q;
            sda_d3_q <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_d3_q;
    assign scl_fall  = ~scl_s2_q & scl_d3_q;
    assign start_evt = scl_s2_q & scl_d3_q & sda_d3_q & ~sda_s2_q;
    assign stop_evt  = scl_s2_q & scl_d3_q & ~sda_d3_q & sda_s2_q;

    assign rx_next = {rx_q[6:0], sda_s2_q};
    assign rd_byte = mem_q[ptr_q];
    assign ptr_inc = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        mem_d   = mem_q;
        if (start_evt) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_evt) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7 && rx_next[7:1] != ADDRESS) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        ack_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_q[0]) begin
                            // Read: first data bit goes out on the same falling edge that ends the ACK.
                            state_d = ST_RDATA;
                            oe_d    = ~rd_byte[7];
                            tx_d    = {rd_byte[6:0], 1'b0};
                            cnt_d   = 4'd1;
                        end else begin
                            state_d = ST_PTR;
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d = ({24'd0, rx_next} < 32'(DEPTH)) ? rx_next[AW-1:0] : '0;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        state_d = ST_DACK;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            mem_d[ptr_q] = rx_next;
                            stb_d        = 1'b1;
                            wa_d         = ptr_q;
                            wd_d         = rx_next;
                            ptr_d        = ptr_inc;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        state_d = ST_DACK;
                    end
                end
                ST_DACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = ST_WDATA;
                        cnt_d   = 4'd0;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q < 4'd8) begin
                            oe_d  = ~tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_RACK;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise && cnt_q == 4'd0) begin
                        ptr_d = ptr_inc;
                        if (sda_s2_q) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_d = ST_RDATA;
                        oe_d    = ~rd_byte[7];
                        tx_d    = {rd_byte[6:0], 1'b0};
                        cnt_d   = 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rx_q    <= 8'd0;
            tx_q    <= 8'd0;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            wa_q    <= '0;
            wd_q    <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_DATA;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            mem_q   <= mem_d;
        end
    end

    // wr_STB is a one-cycle valid with no back-pressure; wr_ADDR/wr_DATA hold until the next write.
    assign so_SDA_OE = oe_q;
    assign s_ACK     = ack_q;
    assign s_BUSY    = busy_q;
    assign wr_STB    = stb_q;
    assign wr_ADDR   = wa_q;
    assign wr_DATA   = wd_q;
    assign dbg_state = state_q;

endmodule
